// File: rtl/instr_fetch.sv
`default_nettype none
//==============================================================================
// Module   : instr_fetch
// Brief    : Fetch stage with credit-limited imem requests, an in-order response
//            queue toward decode, and redirect flush with stale-response discard.
// Revision : 1.0 - initial release
//==============================================================================
module instr_fetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned       c_CNT_W    = $clog2(QDEPTH + 1);
    localparam int unsigned       c_PTR_W    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [c_CNT_W:0]  c_QDEPTH   = (c_CNT_W + 1)'(QDEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(QDEPTH - 1);
    localparam logic [XLEN-1:0]   c_STEP     = XLEN'(4);

    logic [XLEN-1:0]    r_fetch_pc;
    logic [XLEN-1:0]    r_resp_pc;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_discard;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [ILEN-1:0]    r_q_instr [QDEPTH];
    logic [XLEN-1:0]    r_q_pc    [QDEPTH];

    logic               w_credit;
    logic               w_req_fire;
    logic               w_push;
    logic               w_pop;
    logic               w_head_valid;
    logic [XLEN-1:0]    w_redirect_aligned;
    logic               w_unused;

    function automatic logic [c_PTR_W-1:0] f_ptr_next(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_PTR_LAST) ? '0 : ptr + c_PTR_W'(1);
    endfunction

    // Queued words plus in-flight requests may never exceed the queue size.
    assign w_credit           = ({1'b0, r_count} + {1'b0, r_outstanding}) < c_QDEPTH;
    assign imem_req_valid     = rst_n && w_credit && !redirect_valid;
    assign imem_req_addr      = r_fetch_pc;
    assign w_req_fire         = imem_req_valid && imem_req_ready;
    assign w_push             = imem_rsp_valid && !redirect_valid && (r_discard == '0);
    assign w_head_valid       = (r_count != '0);
    assign instr_valid        = w_head_valid && !redirect_valid;
    assign w_pop              = instr_valid && instr_ready;
    assign instr              = w_head_valid ? r_q_instr[r_rd_ptr] : '0;
    assign instr_pc           = w_head_valid ? r_q_pc[r_rd_ptr]    : '0;
    assign w_redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused           = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            r_fetch_pc    <= w_redirect_aligned;
            r_resp_pc     <= w_redirect_aligned;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_outstanding <= r_outstanding - c_CNT_W'(imem_rsp_valid);
            r_discard     <= r_outstanding - c_CNT_W'(imem_rsp_valid);
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + c_STEP;
            end
            r_outstanding <= r_outstanding + c_CNT_W'(w_req_fire) - c_CNT_W'(imem_rsp_valid);
            if (imem_rsp_valid && (r_discard != '0)) begin
                r_discard <= r_discard - c_CNT_W'(1);
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + c_STEP;
                r_wr_ptr  <= f_ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_next(r_rd_ptr);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= imem_rsp_data;
            r_q_pc[r_wr_ptr]    <= r_resp_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
//==============================================================================
// Module   : tb_instr_fetch
// Brief    : Directed bench for instr_fetch; memory returns ~addr as data.
// Revision : 1.0 - initial release
//==============================================================================
module tb_instr_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_instr_valid;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;

    int    checks = 0;
    int    errors = 0;
    int    mem_lat = 1;
    word_t got[$];
    word_t got_w[$];

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(w_req_valid),
        .imem_req_ready(1'b1),
        .imem_req_addr (w_req_addr),
        .imem_rsp_valid(w_rsp_valid),
        .imem_rsp_data (w_rsp_data),
        .instr_valid   (w_instr_valid),
        .instr_ready   (1'b1),
        .instr         (w_instr),
        .instr_pc      (w_instr_pc),
        .redirect_valid(1'b0),
        .redirect_pc   (32'h0)
    );

    always #5 clk = ~clk;

    // Main memory: in-order, fixed latency of mem_lat cycles (1..5).
    logic        fire_s;
    logic [31:0] addr_s;
    logic        pv [0:3];
    logic [31:0] pa [0:3];

    always @(negedge clk) begin
        if (!rst_n) begin
            fire_s <= 1'b0;
        end else begin
            fire_s <= imem_req_valid && imem_req_ready;
            addr_s <= imem_req_addr;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
            for (int i = 0; i < 4; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= 32'h0;
            end
        end else begin
            imem_rsp_valid <= (fire_s && mem_lat == 1) ? 1'b1 : pv[0];
            imem_rsp_data  <= (fire_s && mem_lat == 1) ? ~addr_s : ~pa[0];
            for (int i = 0; i < 3; i++) begin
                pv[i] <= (fire_s && mem_lat == i + 2) ? 1'b1   : pv[i+1];
                pa[i] <= (fire_s && mem_lat == i + 2) ? addr_s : pa[i+1];
            end
            pv[3] <= (fire_s && mem_lat == 5) ? 1'b1   : 1'b0;
            pa[3] <= (fire_s && mem_lat == 5) ? addr_s : 32'h0;
        end
    end

    // Wrap-test memory: single-cycle latency.
    logic        wf_s;
    logic [31:0] wa_s;

    always @(negedge clk) begin
        if (!rst_n) begin
            wf_s <= 1'b0;
        end else begin
            wf_s <= w_req_valid;
            wa_s <= w_req_addr;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_rsp_valid <= 1'b0;
            w_rsp_data  <= 32'h0;
        end else begin
            w_rsp_valid <= wf_s;
            w_rsp_data  <= ~wa_s;
        end
    end

    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) got.push_back({instr_pc, instr});
        if (rst_n && w_instr_valid && got_w.size() < 8) got_w.push_back({w_instr_pc, w_instr});
    end

    // A kept response into a full queue with no pop is a credit violation.
    always @(negedge clk) begin
        if (rst_n && imem_rsp_valid && !redirect_valid && dut.r_discard == 2'd0 &&
            dut.r_count == 2'd2 && !(instr_valid && instr_ready)) begin
            checks++;
            errors++;
            $display("FAIL full_push: push into full queue at %0t (count=%0d, required<2)", $time, dut.r_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b expected 1", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL first_req_addr: got %h expected 0", imem_req_addr); end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 60 && got.size() < 6; k++) tick();
        checks++;
        if (got.size() < 6) begin
            errors++; $display("FAIL stream_timeout: got %0d words expected 6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                logic [31:0] ep;
                ep = 32'(4 * i);
                checks++; if (got[i].pc !== ep) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, got[i].pc, ep); end
                checks++; if (got[i].data !== ~ep) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", i, got[i].data, ~ep); end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        logic [31:0] held_pc;
        logic [31:0] held_instr;
        logic        stable;
        instr_ready = 1'b0;
        exp_pc = got[got.size()-1].pc + 32'd4;
        got.delete();
        repeat (3) tick();
        held_pc    = instr_pc;
        held_instr = instr;
        stable     = 1'b1;
        repeat (7) begin
            tick();
            if (instr_pc !== held_pc || instr !== held_instr || instr_valid !== 1'b1) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL stall_stable: got %b expected 1", stable); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", instr_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL stall_head_pc: got %h expected %h", instr_pc, exp_pc); end
        checks++; if (instr !== ~exp_pc) begin errors++; $display("FAIL stall_head_data: got %h expected %h", instr, ~exp_pc); end
        checks++; if (got.size() != 0) begin errors++; $display("FAIL stall_no_pop: got %0d pops expected 0", got.size()); end
        instr_ready = 1'b1;
        for (int k = 0; k < 60 && got.size() < 4; k++) tick();
        checks++;
        if (got.size() < 4) begin
            errors++; $display("FAIL drain_timeout: got %0d words expected 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                logic [31:0] ep;
                ep = exp_pc + 32'(4 * i);
                checks++; if (got[i].pc !== ep) begin errors++; $display("FAIL drain_pc[%0d]: got %h expected %h", i, got[i].pc, ep); end
                checks++; if (got[i].data !== ~ep) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, got[i].data, ~ep); end
            end
        end
    endtask

    task automatic test_redirect();
        imem_req_ready = 1'b0;
        repeat (6) tick();
        got.delete();
        mem_lat = 3;
        imem_req_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_req_valid: got %b expected 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        checks++; if (dut.r_discard !== 2'd2) begin errors++; $display("FAIL redir_discard: got %0d expected 2", dut.r_discard); end
        for (int k = 0; k < 60 && got.size() < 2; k++) tick();
        checks++;
        if (got.size() < 2) begin
            errors++; $display("FAIL redir_timeout: got %0d words expected 2", got.size());
        end else begin
            checks++; if (got[0].pc !== 32'h100) begin errors++; $display("FAIL redir_pc0: got %h expected 00000100", got[0].pc); end
            checks++; if (got[0].data !== ~32'h100) begin errors++; $display("FAIL redir_data0: got %h expected %h", got[0].data, ~32'h100); end
            checks++; if (got[1].pc !== 32'h104) begin errors++; $display("FAIL redir_pc1: got %h expected 00000104", got[1].pc); end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        for (k = 0; k < 20 && imem_rsp_valid !== 1'b1; k++) tick();
        checks++; if (imem_rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rsp_timeout: got %b expected 1", imem_rsp_valid); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0180;
        got.delete();
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_instr_valid: got %b expected 0", instr_valid); end
        tick();
        redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        for (k = 0; k < 60 && got.size() < 2; k++) tick();
        checks++;
        if (got.size() < 2) begin
            errors++; $display("FAIL b2b_timeout: got %0d words expected 2", got.size());
        end else begin
            checks++; if (got[0].pc !== 32'h200) begin errors++; $display("FAIL b2b_pc0: got %h expected 00000200", got[0].pc); end
            checks++; if (got[0].data !== ~32'h200) begin errors++; $display("FAIL b2b_data0: got %h expected %h", got[0].data, ~32'h200); end
            checks++; if (got[1].pc !== 32'h204) begin errors++; $display("FAIL b2b_pc1: got %h expected 00000204", got[1].pc); end
        end
    endtask

    task automatic test_reset_mid();
        instr_ready = 1'b0;
        repeat (8) tick();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid: got %b expected 1", instr_valid); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_instr_valid: got %b expected 0", instr_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL mid_rst_instr_pc: got %h expected 0", instr_pc); end
        tick();
        tick();
        rst_n = 1'b1;
        got.delete();
        instr_ready = 1'b1;
        #1;
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL restart_addr: got %h expected 0", imem_req_addr); end
        for (int k = 0; k < 60 && got.size() < 3; k++) tick();
        checks++;
        if (got.size() < 3) begin
            errors++; $display("FAIL restart_timeout: got %0d words expected 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic [31:0] ep;
                ep = 32'(4 * i);
                checks++; if (got[i].pc !== ep) begin errors++; $display("FAIL restart_pc[%0d]: got %h expected %h", i, got[i].pc, ep); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pcs [3];
        exp_pcs[0] = 32'hFFFF_FFF8;
        exp_pcs[1] = 32'hFFFF_FFFC;
        exp_pcs[2] = 32'h0000_0000;
        checks++;
        if (got_w.size() < 3) begin
            errors++; $display("FAIL wrap_timeout: got %0d words expected 3", got_w.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (got_w[i].pc !== exp_pcs[i]) begin errors++; $display("FAIL wrap_pc[%0d]: got %h expected %h", i, got_w[i].pc, exp_pcs[i]); end
                checks++; if (got_w[i].data !== ~exp_pcs[i]) begin errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, got_w[i].data, ~exp_pcs[i]); end
            end
        end
    endtask

    initial begin
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
